// File: rtl/count_sequence_checker.sv
// Count sequence checker: locks onto an up-counting stream and flags slips.
// Tracks loss of lock, wrap events and saturating error/wrap statistics.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   en       in   sample strobe; Q_in evaluated only when high
//   Q_in     in   [SIZE-1:0] observed counter value
//   locked   out  high while in LOCKED
//   err      out  one-cycle pulse per mismatch seen while LOCKED
//   wrap     out  one-cycle pulse per correct all-ones-to-zero step in LOCKED
//   err_cnt  out  [CNT_W-1:0] saturating err pulse count
//   wrap_cnt out  [CNT_W-1:0] saturating wrap pulse count
//   state    out  [1:0] IDLE=0, ACQ=1, LOCKED=2, LOST=3
module count_sequence_checker #(
  parameter int SIZE     = 4,
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SIZE-1:0]  Q_in,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } state_e;

  localparam logic [SIZE-1:0]  Q_ONE   = SIZE'(1);
  localparam logic [SIZE-1:0]  Q_ZERO  = '0;
  localparam logic [3:0]       RUN_ONE = 4'd1;
  localparam logic [3:0]       LOCK_T  = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_T  = 4'(LOSS_CNT);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX   = '1;

  state_e           state_q, state_d;
  logic [SIZE-1:0]  prev_q, prev_d;
  logic [3:0]       good_q, good_d;
  logic [3:0]       bad_q, bad_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic [SIZE-1:0]  exp_val;
  logic             match;
  logic             q_zero;
  logic [3:0]       good_inc;
  logic [3:0]       bad_inc;
  logic             lock_hit;
  logic             loss_hit;

  // Expected value wraps naturally modulo 2^SIZE.
  assign exp_val  = prev_q + Q_ONE;
  assign match    = (Q_in == exp_val);
  assign q_zero   = (Q_in == Q_ZERO);
  assign good_inc = good_q + RUN_ONE;
  assign bad_inc  = bad_q + RUN_ONE;
  assign lock_hit = (good_inc == LOCK_T);
  assign loss_hit = (bad_inc == LOSS_T);

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      err_q      <= 1'b0;
      wrap_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      wrap_q     <= wrap_d;
      locked_q   <= locked_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        IDLE:    state_d = ACQ;
        ACQ:     if (match && lock_hit) state_d = LOCKED;
        LOCKED:  if (!match && loss_hit) state_d = LOST;
        LOST:    state_d = ACQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Run counters and last-sample register.
  // A mismatch in ACQ restarts the run on the new value, since prev
  // is always reloaded from Q_in.
  always_comb begin
    prev_d = prev_q;
    good_d = good_q;
    bad_d  = bad_q;
    if (en) begin
      prev_d = Q_in;
      unique case (state_q)
        IDLE: begin
          good_d = '0;
          bad_d  = '0;
        end
        ACQ: begin
          good_d = match ? good_inc : 4'd0;
          bad_d  = '0;
        end
        LOCKED: begin
          bad_d = match ? 4'd0 : bad_inc;
        end
        LOST: begin
          good_d = '0;
          bad_d  = '0;
        end
        default: begin
          good_d = '0;
          bad_d  = '0;
        end
      endcase
    end
  end

  // Output logic: pulses only come from evaluated samples in LOCKED,
  // and err/wrap are mutually exclusive through match.
  always_comb begin
    err_d      = 1'b0;
    wrap_d     = 1'b0;
    locked_d   = (state_d == LOCKED);
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    if (en && state_q == LOCKED) begin
      err_d  = !match;
      wrap_d = match && q_zero;
    end
    if (err_d && err_cnt_q != C_MAX)
      err_cnt_d = err_cnt_q + C_ONE;
    if (wrap_d && wrap_cnt_q != C_MAX)
      wrap_cnt_d = wrap_cnt_q + C_ONE;
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign wrap     = wrap_q;
  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Bench for count_sequence_checker: vector table through a scoreboard
// queue, plus a saturation sequence on a narrow-counter instance.
module tb_count_sequence_checker;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] q;
  logic       locked, err, wrap;
  logic [7:0] err_cnt, wrap_cnt;
  logic [1:0] state;

  logic       rst2, en2;
  logic [3:0] q2;
  logic       locked2, err2, wrap2;
  logic [1:0] err_cnt2, wrap_cnt2;
  logic [1:0] state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_sequence_checker #(
    .SIZE(4), .LOCK_CNT(3), .LOSS_CNT(2), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .Q_in(q),
    .locked(locked), .err(err), .wrap(wrap),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .state(state)
  );

  count_sequence_checker #(
    .SIZE(4), .LOCK_CNT(3), .LOSS_CNT(15), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .Q_in(q2),
    .locked(locked2), .err(err2), .wrap(wrap2),
    .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2), .state(state2)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] q;
    logic [1:0] st;
    logic       lk;
    logic       er;
    logic       wr;
    logic [7:0] ec;
    logic [7:0] wc;
  } vec_t;

  localparam int NV = 39;
  vec_t tbl [NV];
  vec_t sbq [$];
  vec_t e;

  function automatic vec_t mk(
    input logic r, input logic n, input int qv,
    input int st, input logic lk, input logic er, input logic wr,
    input int ec, input int wc
  );
    vec_t v;
    v.rst = r;
    v.en  = n;
    v.q   = 4'(qv);
    v.st  = 2'(st);
    v.lk  = lk;
    v.er  = er;
    v.wr  = wr;
    v.ec  = 8'(ec);
    v.wc  = 8'(wc);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1; en  = 1'b0; q  = '0;
    rst2 = 1'b1; en2 = 1'b0; q2 = '0;

    //            rst en q   st lk er wr ec wc
    tbl[0]  = mk(1, 1, 5,   0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 10,  0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0,   1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 1,   1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 2,   1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 3,   2, 1, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 9,   2, 1, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 9,   2, 1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 9,   2, 1, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 9,   2, 1, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 9,   2, 1, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 4,   2, 1, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 5,   2, 1, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, 7,   2, 1, 1, 0, 1, 0);
    tbl[14] = mk(0, 1, 8,   2, 1, 0, 0, 1, 0);
    tbl[15] = mk(0, 1, 3,   2, 1, 1, 0, 2, 0);
    tbl[16] = mk(0, 1, 9,   3, 0, 1, 0, 3, 0);
    tbl[17] = mk(0, 1, 6,   1, 0, 0, 0, 3, 0);
    tbl[18] = mk(0, 1, 7,   1, 0, 0, 0, 3, 0);
    tbl[19] = mk(0, 1, 2,   1, 0, 0, 0, 3, 0);
    tbl[20] = mk(0, 1, 3,   1, 0, 0, 0, 3, 0);
    tbl[21] = mk(0, 1, 4,   1, 0, 0, 0, 3, 0);
    tbl[22] = mk(0, 0, 4,   1, 0, 0, 0, 3, 0);
    tbl[23] = mk(0, 1, 5,   2, 1, 0, 0, 3, 0);
    tbl[24] = mk(1, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[25] = mk(0, 1, 10,  1, 0, 0, 0, 0, 0);
    tbl[26] = mk(0, 1, 11,  1, 0, 0, 0, 0, 0);
    tbl[27] = mk(0, 1, 12,  1, 0, 0, 0, 0, 0);
    tbl[28] = mk(0, 1, 13,  2, 1, 0, 0, 0, 0);
    tbl[29] = mk(0, 1, 14,  2, 1, 0, 0, 0, 0);
    tbl[30] = mk(0, 1, 15,  2, 1, 0, 0, 0, 0);
    tbl[31] = mk(0, 1, 0,   2, 1, 0, 1, 0, 1);
    tbl[32] = mk(0, 1, 1,   2, 1, 0, 0, 0, 1);
    tbl[33] = mk(0, 0, 2,   2, 1, 0, 0, 0, 1);
    tbl[34] = mk(1, 0, 2,   0, 0, 0, 0, 0, 0);
    tbl[35] = mk(0, 1, 3,   1, 0, 0, 0, 0, 0);
    tbl[36] = mk(0, 1, 4,   1, 0, 0, 0, 0, 0);
    tbl[37] = mk(0, 1, 5,   1, 0, 0, 0, 0, 0);
    tbl[38] = mk(0, 1, 6,   2, 1, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      en  = tbl[i].en;
      q   = tbl[i].q;
      sbq.push_back(tbl[i]);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
        chk($sformatf("v%0d.queue", i), 0, 1);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("v%0d.state", i), int'(state), int'(e.st));
        chk($sformatf("v%0d.locked", i), int'(locked), int'(e.lk));
        chk($sformatf("v%0d.err", i), int'(err), int'(e.er));
        chk($sformatf("v%0d.wrap", i), int'(wrap), int'(e.wr));
        chk($sformatf("v%0d.err_cnt", i), int'(err_cnt), int'(e.ec));
        chk($sformatf("v%0d.wrap_cnt", i), int'(wrap_cnt), int'(e.wc));
        chk($sformatf("v%0d.excl", i), int'(err & wrap), 0);
      end
    end

    // Saturation: narrow counters, loss threshold never reached.
    @(negedge clk);
    rst2 = 1'b1; en2 = 1'b1; q2 = 4'd7;
    @(posedge clk); #1;
    chk("sat.reset_cnt", int'(err_cnt2), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst2 = 1'b0; en2 = 1'b1; q2 = 4'(i);
      @(posedge clk);
    end
    #1;
    chk("sat.locked", int'(locked2), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en2 = 1'b1; q2 = 4'd0;
      @(posedge clk); #1;
      chk($sformatf("sat.err%0d", i), int'(err2), 1);
      chk($sformatf("sat.cnt%0d", i), int'(err_cnt2), (i < 3) ? i + 1 : 3);
      chk($sformatf("sat.state%0d", i), int'(state2), 2);
    end
    @(negedge clk);
    en2 = 1'b0;
    @(posedge clk); #1;
    chk("sat.hold", int'(err_cnt2), 3);
    chk("sat.nopulse", int'(err2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sequence_checker.md
COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

Interface
REQ-001 Parameter SIZE, default 4: width of the observed count value.
REQ-002 Parameter LOCK_CNT, default 3: consecutive correct increments required to lock (range 1..15).
REQ-003 Parameter LOSS_CNT, default 2: consecutive mismatches while locked that declare loss of lock (range 1..15).
REQ-004 Parameter CNT_W, default 8: width of the err_cnt and wrap_cnt statistics counters.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  sample strobe; Q_in is evaluated only on edges where en=1.
REQ-008 Q_in  input  SIZE  observed count value from a synchronous up-counter.
REQ-009 locked  output  1  high while the state is LOCKED.
REQ-010 err  output  1  one-cycle pulse per mismatch detected in LOCKED.
REQ-011 wrap  output  1  one-cycle pulse per correct all-ones-to-zero transition in LOCKED.
REQ-012 err_cnt  output  CNT_W  saturating count of err pulses.
REQ-013 wrap_cnt  output  CNT_W  saturating count of wrap pulses.
REQ-014 state  output  2  current state encoding: IDLE=0, ACQ=1, LOCKED=2, LOST=3.

Function
REQ-015 Expected value SHALL be prev+1 modulo 2^SIZE, where prev is the last Q_in sampled with en=1; match = (Q_in == expected).
REQ-016 Every en=1 edge SHALL load Q_in into prev, in every state.
REQ-017 With en=0: state, prev, and all counters SHALL hold; err and wrap SHALL be 0.
REQ-018 IDLE: on en=1, SHALL store the sample, clear the good-run counter, and go to ACQ; no err.
REQ-019 ACQ: match SHALL increment the good-run counter; when it reaches LOCK_CNT, go to LOCKED in the same edge.
REQ-020 ACQ: mismatch SHALL clear the good-run counter and stay in ACQ (resync on the new value); no err.
REQ-021 LOCKED: match SHALL clear the bad-run counter; if additionally Q_in==0, SHALL pulse wrap and increment wrap_cnt.
REQ-022 LOCKED: mismatch SHALL pulse err, increment err_cnt, and increment the bad-run counter; when it reaches LOSS_CNT, go to LOST.
REQ-023 LOST: on en=1, SHALL go to ACQ with the good-run counter cleared; no err, no wrap.
REQ-024 err, wrap, locked, and state SHALL be registered, updating on the same edge that samples Q_in (visible one cycle after the sample is presented).
REQ-025 err_cnt and wrap_cnt SHALL saturate at 2^CNT_W-1 and never wrap to 0.
REQ-026 err and wrap SHALL never both be 1 in the same cycle.

Reset
REQ-027 rst=1 SHALL force state=IDLE, locked=0, err=0, wrap=0, err_cnt=0, wrap_cnt=0, prev=0, and clear the good-run and bad-run counters on the next edge; rst overrides en.
REQ-028 Reset asserted in any state, including mid-LOCKED, SHALL discard lock history; relock requires a full LOCK_CNT acquisition.

Verification (SIZE=4, LOCK_CNT=3, LOSS_CNT=2, CNT_W=8 unless stated)
REQ-029 Reset: rst=1 for 2 cycles with en=1 and Q_in toggling -> state=0, all outputs 0.
REQ-030 Acquire: en=1, Q_in=0,1,2,3 on consecutive edges -> state=1 after 0; locked=1 and state=2 after the edge sampling 3.
REQ-031 Wrap: locked, Q_in=14,15,0,1 -> wrap=1 for exactly the cycle after sampling 0; wrap_cnt=1; err stays 0.
REQ-032 Errors/loss: locked at prev=5, Q_in=7 -> err pulse, err_cnt=1, still locked; then Q_in=8 (match) -> no err; then Q_in=3 and Q_in=9 -> err_cnt=3, state=LOST; next en -> ACQ.
REQ-033 Gaps/saturation: locked stream with en=0 for 5 cycles between samples -> lock holds, no pulses; with CNT_W=2, 6 forced mismatches in LOCKED with LOSS_CNT=15 -> err_cnt stops at 3.
